// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RX    = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL    = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  // Bit counter values seen on the parity and stop falls (start fall is not counted).
  localparam logic [3:0] PS2_PAR_BIT  = 4'(PS2_FRAME_BITS - 3);
  localparam logic [3:0] PS2_STOP_BIT = 4'(PS2_FRAME_BITS - 2);

  function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
    return (^{data, par}) & stop;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length deglitch filter for one PS/2 pin.
// o_fall pulses for one cycle in the cycle after the filtered line drops 1->0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_filt,
  output logic o_fall
);

  localparam int CNT_W = $clog2(FILTER_LEN);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;
  logic             r_fall;

  // r_cnt counts consecutive synchronised samples that disagree with r_filt.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pin};
      r_fall <= 1'b0;
      if (r_sync[1] != r_filt) begin
        if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
          r_filt <= r_sync[1];
          r_cnt  <= '0;
          r_fall <= r_filt;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;
  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver folding E0/F0 prefixes into flags.
// Define PS2_TIMEOUT_EN to abort frames whose clock stalls for TIMEOUT_CYC cycles.
//   state | meaning
//   IDLE  | waiting for a start-bit fall (data low)
//   RX    | shifting data, parity and stop bits on each fall
//   CHECK | one cycle while the frame result (strobe/err) is presented
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 56000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       i_ps2_kbd_clk,
  input  logic       i_ps2_kbd_data,
  output logic [7:0] o_code,
  output logic       o_release,
  output logic       o_extended,
  output logic       o_strobe,
  output logic       o_frame_err,
  output logic       o_busy
);

  if (FILTER_LEN < 2 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("ps2_scancode_rx: FILTER_LEN and TIMEOUT_CYC must both be at least 2");
  end

  logic w_fall, w_data, w_clk_filt_unused, w_data_fall_unused, w_to_exp;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_pin   (i_ps2_kbd_clk),
    .o_filt  (w_clk_filt_unused),
    .o_fall  (w_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .i_pin   (i_ps2_kbd_data),
    .o_filt  (w_data),
    .o_fall  (w_data_fall_unused)
  );

  rx_state_t  r_state, w_state_nx;
  logic [3:0] r_bit, w_bit_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_par, w_par_nx;
  logic       r_ext, w_ext_nx;
  logic       r_rel, w_rel_nx;
  logic [7:0] r_code, w_code_nx;
  logic       r_rel_o, w_rel_o_nx;
  logic       r_ext_o, w_ext_o_nx;
  logic       r_strobe, w_strobe_nx;
  logic       r_err, w_err_nx;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to;

  // Down-counter held full outside RX and on every fall; expiry is the zero compare.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                   r_to <= '0;
    else if (r_state != RX || w_fall) r_to <= TO_W'(TIMEOUT_CYC - 1);
    else if (!w_to_exp)             r_to <= r_to - 1'b1;
  end

  assign w_to_exp = (r_state == RX) && (r_to == '0);
`else
  assign w_to_exp = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_bit_nx    = r_bit;
    w_shift_nx  = r_shift;
    w_par_nx    = r_par;
    w_ext_nx    = r_ext;
    w_rel_nx    = r_rel;
    w_code_nx   = r_code;
    w_rel_o_nx  = r_rel_o;
    w_ext_o_nx  = r_ext_o;
    w_strobe_nx = 1'b0;
    w_err_nx    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall && !w_data) begin
          w_state_nx = RX;
          w_bit_nx   = '0;
        end
      end
      RX: begin
        if (w_fall) begin
          w_bit_nx = r_bit + 4'd1;
          if (r_bit < PS2_PAR_BIT) begin
            w_shift_nx = {w_data, r_shift[7:1]};
          end else if (r_bit == PS2_PAR_BIT) begin
            w_par_nx = w_data;
          end else begin
            w_state_nx = CHECK;
            w_bit_nx   = '0;
            if (frame_ok(r_shift, r_par, w_data)) begin
              if (r_shift == PS2_PFX_EXT) begin
                w_ext_nx = 1'b1;
              end else if (r_shift == PS2_PFX_REL) begin
                w_rel_nx = 1'b1;
              end else begin
                w_strobe_nx = 1'b1;
                w_code_nx   = r_shift;
                w_rel_o_nx  = r_rel;
                w_ext_o_nx  = r_ext;
                w_ext_nx    = 1'b0;
                w_rel_nx    = 1'b0;
              end
            end else begin
              w_err_nx = 1'b1;
              w_ext_nx = 1'b0;
              w_rel_nx = 1'b0;
            end
          end
        end else if (w_to_exp) begin
          w_state_nx = IDLE;
          w_bit_nx   = '0;
          w_err_nx   = 1'b1;
          w_ext_nx   = 1'b0;
          w_rel_nx   = 1'b0;
        end
      end
      CHECK: begin
        w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_ext    <= 1'b0;
      r_rel    <= 1'b0;
      r_code   <= '0;
      r_rel_o  <= 1'b0;
      r_ext_o  <= 1'b0;
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_bit    <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_par    <= w_par_nx;
      r_ext    <= w_ext_nx;
      r_rel    <= w_rel_nx;
      r_code   <= w_code_nx;
      r_rel_o  <= w_rel_o_nx;
      r_ext_o  <= w_ext_o_nx;
      r_strobe <= w_strobe_nx;
      r_err    <= w_err_nx;
    end
  end

  assign o_code      = r_code;
  assign o_release   = r_rel_o;
  assign o_extended  = r_ext_o;
  assign o_strobe    = r_strobe;
  assign o_frame_err = r_err;
  assign o_busy      = (r_state == RX);

endmodule
